// File: rtl/ac_motor_pwm_compare.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_compare
// Consumer side of the AC motor carrier. Three signed phase references are
// shadowed on the carrier-peak LOCK pulse, compared against the shared
// triangle carrier, and turned into complementary high/low-side gate signals
// with dead-time insertion. A carrier watchdog latches FAULT and forces all
// gates off if LOCK stops arriving.
//
// Ports
//   clk_i                 system clock, rising edge
//   reset_i               synchronous, active-high reset
//   enable_i              1 = modulate, 0 = all gates off
//   lock_i                one-cycle pulse per carrier period at positive peak
//   triangle_i            signed carrier
//   ref_u_i/ref_v_i/ref_w_i  signed phase references
//   hs_u_o/hs_v_o/hs_w_o  high-side gates, active high
//   ls_u_o/ls_v_o/ls_w_o  low-side gates, active high
//   fault_o               sticky carrier-watchdog fault
// ---------------------------------------------------------------------------
module ac_motor_pwm_compare #(
   parameter int unsigned OUTPUT_BITS     = 24,
   parameter int unsigned DEAD_CYCLES     = 50,
   parameter int unsigned DEAD_BITS       = 8,
   parameter int unsigned WATCHDOG_CYCLES = 2**20
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   lock_i,
   input  logic [OUTPUT_BITS-1:0] triangle_i,
   input  logic [OUTPUT_BITS-1:0] ref_u_i,
   input  logic [OUTPUT_BITS-1:0] ref_v_i,
   input  logic [OUTPUT_BITS-1:0] ref_w_i,
   output logic                   hs_u_o,
   output logic                   hs_v_o,
   output logic                   hs_w_o,
   output logic                   ls_u_o,
   output logic                   ls_v_o,
   output logic                   ls_w_o,
   output logic                   fault_o
);

   localparam int unsigned NUM_PHASES = 3;
   localparam int unsigned WD_BITS    = $clog2(WATCHDOG_CYCLES + 1);

   localparam logic [DEAD_BITS-1:0] DEAD_LOAD = DEAD_BITS'(DEAD_CYCLES - 1);
   localparam logic [WD_BITS-1:0]   WD_LIMIT  = WD_BITS'(WATCHDOG_CYCLES);

   // Encoding chosen so bit 1 is the high-side gate and bit 0 the low-side
   // gate: the state register drives the gate pins directly.
   typedef enum logic [3:0] {
      ST_OFF  = 4'b0000,
      ST_LOW  = 4'b0001,
      ST_HIGH = 4'b0010,
      ST_DT_H = 4'b0100,
      ST_DT_L = 4'b1000
   } phase_state_e;

   logic [OUTPUT_BITS-1:0] ref_in    [NUM_PHASES];
   logic [OUTPUT_BITS-1:0] ref_act_q [NUM_PHASES];
   logic [OUTPUT_BITS-1:0] ref_act_d [NUM_PHASES];
   logic                   armed_q, armed_d;
   logic [NUM_PHASES-1:0]  demand_q, demand_d;
   phase_state_e           state_q   [NUM_PHASES];
   phase_state_e           state_d   [NUM_PHASES];
   logic [DEAD_BITS-1:0]   cnt_q     [NUM_PHASES];
   logic [DEAD_BITS-1:0]   cnt_d     [NUM_PHASES];
   logic [WD_BITS-1:0]     wd_cnt_q, wd_cnt_d;
   logic                   fault_q, fault_d;

   assign ref_in[0] = ref_u_i;
   assign ref_in[1] = ref_v_i;
   assign ref_in[2] = ref_w_i;

   // Shadow references: only the value present on the LOCK edge takes effect.
   always_comb begin
      armed_d = armed_q;
      for (int p = 0; p < NUM_PHASES; p++) begin
         ref_act_d[p] = ref_act_q[p];
      end
      if (lock_i) begin
         armed_d = 1'b1;
         for (int p = 0; p < NUM_PHASES; p++) begin
            ref_act_d[p] = ref_in[p];
         end
      end
   end

   // Full-width signed compare, no clamping.
   always_comb begin
      demand_d = '0;
      for (int p = 0; p < NUM_PHASES; p++) begin
         demand_d[p] = $signed(ref_act_q[p]) > $signed(triangle_i);
      end
   end

   // Carrier watchdog: saturating count of cycles since the last LOCK.
   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (lock_i || !enable_i) begin
         wd_cnt_d = '0;
      end else if (wd_cnt_q != WD_LIMIT) begin
         wd_cnt_d = wd_cnt_q + WD_BITS'(1);
      end
      fault_d = fault_q | (wd_cnt_d == WD_LIMIT);
   end

   // Per-phase gate FSM with dead-time counter.
   always_comb begin
      for (int p = 0; p < NUM_PHASES; p++) begin
         state_d[p] = state_q[p];
         cnt_d[p]   = cnt_q[p];
         if (!enable_i || fault_q) begin
            state_d[p] = ST_OFF;
         end else begin
            unique case (state_q[p])
               ST_OFF: begin
                  if (armed_q) begin
                     state_d[p] = demand_q[p] ? ST_DT_H : ST_DT_L;
                     cnt_d[p]   = DEAD_LOAD;
                  end
               end
               ST_DT_H: begin
                  // Demand withdrawn before HS asserted: fall straight back.
                  if (!demand_q[p]) begin
                     state_d[p] = ST_LOW;
                  end else if (cnt_q[p] == '0) begin
                     state_d[p] = ST_HIGH;
                  end else begin
                     cnt_d[p] = cnt_q[p] - DEAD_BITS'(1);
                  end
               end
               ST_HIGH: begin
                  if (!demand_q[p]) begin
                     state_d[p] = ST_DT_L;
                     cnt_d[p]   = DEAD_LOAD;
                  end
               end
               ST_DT_L: begin
                  if (demand_q[p]) begin
                     state_d[p] = ST_HIGH;
                  end else if (cnt_q[p] == '0) begin
                     state_d[p] = ST_LOW;
                  end else begin
                     cnt_d[p] = cnt_q[p] - DEAD_BITS'(1);
                  end
               end
               ST_LOW: begin
                  if (demand_q[p]) begin
                     state_d[p] = ST_DT_H;
                     cnt_d[p]   = DEAD_LOAD;
                  end
               end
               default: begin
                  state_d[p] = ST_OFF;
               end
            endcase
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         armed_q  <= 1'b0;
         demand_q <= '0;
         wd_cnt_q <= '0;
         fault_q  <= 1'b0;
         for (int p = 0; p < NUM_PHASES; p++) begin
            ref_act_q[p] <= '0;
            state_q[p]   <= ST_OFF;
            cnt_q[p]     <= '0;
         end
      end else begin
         armed_q  <= armed_d;
         demand_q <= demand_d;
         wd_cnt_q <= wd_cnt_d;
         fault_q  <= fault_d;
         for (int p = 0; p < NUM_PHASES; p++) begin
            ref_act_q[p] <= ref_act_d[p];
            state_q[p]   <= state_d[p];
            cnt_q[p]     <= cnt_d[p];
         end
      end
   end

   assign hs_u_o  = state_q[0][1];
   assign hs_v_o  = state_q[1][1];
   assign hs_w_o  = state_q[2][1];
   assign ls_u_o  = state_q[0][0];
   assign ls_v_o  = state_q[1][0];
   assign ls_w_o  = state_q[2][0];
   assign fault_o = fault_q;

endmodule

// File: tb/tb_ac_motor_pwm_compare.sv
// ---------------------------------------------------------------------------
// tb_ac_motor_pwm_compare
// Directed bench: a 400-cycle triangle carrier (peak at phase 200, LOCK there)
// scaled by 2**16. Expected gate/fault values at specific edges are queued by
// the stimulus thread; a monitor pops and compares them as the run reaches
// those edges, and also checks gate overlap and handover dead time.
// ---------------------------------------------------------------------------
module tb_ac_motor_pwm_compare;

   localparam int unsigned OB     = 24;
   localparam int unsigned DC     = 50;
   localparam int unsigned DB     = 8;
   localparam int unsigned WD     = 1000;
   localparam int          PERIOD = 400;
   localparam int          SCALE  = 65536;

   localparam logic [6:0] M_ALL = 7'b1111111;
   localparam logic [6:0] M_F   = 7'b1000000;
   localparam logic [6:0] M_U   = 7'b0110000;
   localparam logic [6:0] M_V   = 7'b0001100;
   localparam logic [6:0] M_W   = 7'b0000011;

   logic          clk = 1'b0;
   logic          reset_i, enable_i, lock_i;
   logic [OB-1:0] triangle_i, ref_u_i, ref_v_i, ref_w_i;
   logic          hs_u_o, hs_v_o, hs_w_o, ls_u_o, ls_v_o, ls_w_o, fault_o;

   always #5 clk = ~clk;

   ac_motor_pwm_compare #(
      .OUTPUT_BITS    (OB),
      .DEAD_CYCLES    (DC),
      .DEAD_BITS      (DB),
      .WATCHDOG_CYCLES(WD)
   ) dut (
      .clk_i     (clk),
      .reset_i   (reset_i),
      .enable_i  (enable_i),
      .lock_i    (lock_i),
      .triangle_i(triangle_i),
      .ref_u_i   (ref_u_i),
      .ref_v_i   (ref_v_i),
      .ref_w_i   (ref_w_i),
      .hs_u_o    (hs_u_o),
      .hs_v_o    (hs_v_o),
      .hs_w_o    (hs_w_o),
      .ls_u_o    (ls_u_o),
      .ls_v_o    (ls_v_o),
      .ls_w_o    (ls_w_o),
      .fault_o   (fault_o)
   );

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         at;
      logic [6:0] mask;
      logic [6:0] val;
      string      name;
   } exp_t;

   exp_t sb_q[$];

   logic          lock_en   = 1'b1;
   logic          force_en  = 1'b0;
   logic [OB-1:0] force_val = 24'h800000;

   logic [6:0] obs;
   assign obs = {fault_o, hs_u_o, ls_u_o, hs_v_o, ls_v_o, hs_w_o, ls_w_o};

   // Triangle in units of 2**16: -100 at phase 0, +100 at phase 200.
   function automatic int tri_units(input int k);
      if (k <= 200) return k - 100;
      return 300 - k;
   endfunction

   function automatic void expect_at(input int at, input logic [6:0] mask,
                                     input logic [6:0] val, input string name);
      exp_t e;
      e.at   = at;
      e.mask = mask;
      e.val  = val;
      e.name = name;
      sb_q.push_back(e);
   endfunction

   // Inputs driven here are sampled on edge edge_cnt+1.
   task automatic drive_carrier();
      int k;
      k = (edge_cnt + 1) % PERIOD;
      triangle_i = force_en ? force_val : OB'(tri_units(k) * SCALE);
      lock_i     = lock_en && (k == 200);
   endtask

   // Return at the falling edge just before edge n, carrier for edge n applied.
   task automatic goto(input int n);
      while (edge_cnt < n - 1) begin
         @(negedge clk);
         drive_carrier();
      end
   endtask

   // Monitor: scoreboard pops plus overlap / dead-time checks.
   int   last_gate [3];
   int   fall_at   [3];
   logic prev_hs   [3];
   logic prev_ls   [3];

   initial begin
      exp_t       e;
      logic [2:0] hs, ls;
      for (int p = 0; p < 3; p++) begin
         last_gate[p] = 0;
         fall_at[p]   = 0;
         prev_hs[p]   = 1'b0;
         prev_ls[p]   = 1'b0;
      end
      forever begin
         @(posedge clk);
         #1;
         while (sb_q.size() > 0 && sb_q[0].at < edge_cnt) begin
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: edge %0d was skipped (now %0d)", e.name, e.at, edge_cnt);
         end
         while (sb_q.size() > 0 && sb_q[0].at == edge_cnt) begin
            e = sb_q.pop_front();
            checks++;
            if ((obs & e.mask) !== (e.val & e.mask)) begin
               errors++;
               $display("FAIL %s at edge %0d: got %b required %b (mask %b)",
                        e.name, e.at, obs & e.mask, e.val & e.mask, e.mask);
            end
         end
         hs = {hs_w_o, hs_v_o, hs_u_o};
         ls = {ls_w_o, ls_v_o, ls_u_o};
         for (int p = 0; p < 3; p++) begin
            checks++;
            if (hs[p] === 1'b1 && ls[p] === 1'b1) begin
               errors++;
               $display("FAIL overlap phase %0d at edge %0d: hs=1 ls=1 required not both", p, edge_cnt);
            end
            if (prev_hs[p] && !hs[p]) begin
               last_gate[p] = 1;
               fall_at[p]   = edge_cnt;
            end
            if (prev_ls[p] && !ls[p]) begin
               last_gate[p] = 2;
               fall_at[p]   = edge_cnt;
            end
            if (!prev_hs[p] && hs[p] && last_gate[p] == 2) begin
               checks++;
               if (edge_cnt - fall_at[p] != int'(DC)) begin
                  errors++;
                  $display("FAIL deadtime_ls_to_hs phase %0d at edge %0d: gap %0d required %0d",
                           p, edge_cnt, edge_cnt - fall_at[p], DC);
               end
            end
            if (!prev_ls[p] && ls[p] && last_gate[p] == 1) begin
               checks++;
               if (edge_cnt - fall_at[p] != int'(DC)) begin
                  errors++;
                  $display("FAIL deadtime_hs_to_ls phase %0d at edge %0d: gap %0d required %0d",
                           p, edge_cnt, edge_cnt - fall_at[p], DC);
               end
            end
            prev_hs[p] = hs[p];
            prev_ls[p] = ls[p];
            if (reset_i || !enable_i || fault_o) last_gate[p] = 0;
         end
      end
   end

   // Stimulus.
   initial begin
      reset_i  = 1'b1;
      enable_i = 1'b0;
      ref_u_i  = '0;
      ref_v_i  = OB'(64 * SCALE);
      ref_w_i  = OB'(-64 * SCALE);
      drive_carrier();

      // Reset, unarmed, first arming and the 50% period for phase U.
      expect_at(3,   M_ALL, 7'b0000000, "reset_state");
      expect_at(150, M_ALL, 7'b0000000, "unarmed_off");
      expect_at(200, M_ALL, 7'b0000000, "lock_edge_off");
      expect_at(237, M_V,   7'b0000000, "v_dt_l");
      expect_at(238, M_V,   7'b0001000, "v_direct_high");
      expect_at(250, M_U,   7'b0000000, "u_arm_dead");
      expect_at(251, M_U,   7'b0010000, "u_arm_low");
      expect_at(301, M_U,   7'b0010000, "u_low_before_cross");
      expect_at(302, M_U,   7'b0000000, "u_ls_release");
      expect_at(351, M_U,   7'b0000000, "u_dead_to_high");
      expect_at(352, M_U,   7'b0100000, "u_high_on");
      expect_at(500, M_U,   7'b0100000, "u_high_hold");
      expect_at(501, M_U,   7'b0000000, "u_hs_release");
      expect_at(550, M_U,   7'b0000000, "u_dead_to_low");
      expect_at(551, M_U,   7'b0010000, "u_low_on");

      goto(4);
      reset_i  = 1'b0;
      enable_i = 1'b1;

      // Short demand pulse while LOW: no HS, LS returns.
      goto(560);
      expect_at(560, M_U, 7'b0010000, "pulse_low_before");
      expect_at(561, M_U, 7'b0000000, "pulse_ls_release");
      expect_at(565, M_U, 7'b0000000, "pulse_no_hs");
      expect_at(570, M_U, 7'b0000000, "pulse_still_dead");
      expect_at(571, M_U, 7'b0010000, "pulse_ls_return");
      force_en = 1'b1;
      drive_carrier();
      goto(570);
      force_en = 1'b0;
      drive_carrier();

      // Reference step between LOCKs takes effect only after the next LOCK.
      goto(650);
      ref_u_i = OB'(64 * SCALE);
      expect_at(701,  M_U, 7'b0010000, "step_old_low");
      expect_at(702,  M_U, 7'b0000000, "step_old_release");
      expect_at(751,  M_U, 7'b0000000, "step_old_dead");
      expect_at(752,  M_U, 7'b0100000, "step_old_high");
      expect_at(900,  M_U, 7'b0100000, "step_old_high_hold");
      expect_at(901,  M_U, 7'b0000000, "step_old_hs_off");
      expect_at(950,  M_U, 7'b0000000, "step_old_dead2");
      expect_at(951,  M_U, 7'b0010000, "step_old_low_on");
      expect_at(1037, M_U, 7'b0010000, "step_new_low");
      expect_at(1038, M_U, 7'b0000000, "step_new_release");
      expect_at(1087, M_U, 7'b0000000, "step_new_dead");
      expect_at(1088, M_U, 7'b0100000, "step_new_high");
      expect_at(1364, M_U, 7'b0100000, "step_new_high_hold");
      expect_at(1365, M_U, 7'b0000000, "step_new_hs_off");
      expect_at(1414, M_U, 7'b0000000, "step_new_dead2");
      expect_at(1415, M_U, 7'b0010000, "step_new_low_on");

      // Reference changed on the LOCK edge itself is captured.
      goto(1400);
      ref_w_i = OB'(-32 * SCALE);
      expect_at(1533, M_W, 7'b0000001, "w_capture_low");
      expect_at(1534, M_W, 7'b0000000, "w_capture_release");
      expect_at(1583, M_W, 7'b0000000, "w_capture_dead");
      expect_at(1584, M_W, 7'b0000010, "w_capture_high");

      // ENABLE drop while HS_V high, then re-enable with full dead time.
      goto(1699);
      expect_at(1699, M_V,   7'b0001000, "v_high_before_disable");
      expect_at(1700, M_ALL, 7'b0000000, "disable_all_off");
      expect_at(1710, M_ALL, 7'b0000000, "reenable_edge_off");
      expect_at(1759, M_ALL, 7'b0000000, "reenable_dead_end");
      expect_at(1760, M_ALL, 7'b0101001, "reenable_gates_on");
      goto(1700);
      enable_i = 1'b0;
      goto(1710);
      enable_i = 1'b1;

      // Reset mid-PWM: gates off, nothing until the next LOCK.
      goto(1900);
      expect_at(1900, M_ALL, 7'b0000000, "midrun_reset_off");
      expect_at(1903, M_ALL, 7'b0000000, "after_reset_off");
      expect_at(2000, M_ALL, 7'b0000000, "unarmed_after_reset");
      expect_at(2200, M_ALL, 7'b0000000, "rearm_lock_edge");
      expect_at(2237, M_ALL, 7'b0000000, "rearm_dead");
      expect_at(2238, M_ALL, 7'b0101000, "rearm_direct_high");
      expect_at(2250, M_ALL, 7'b0101000, "rearm_w_dead");
      expect_at(2251, M_ALL, 7'b0101001, "rearm_w_low");
      reset_i = 1'b1;
      goto(1903);
      reset_i = 1'b0;

      // Watchdog: last LOCK at edge 2200, FAULT at 2200+WD, sticky.
      goto(2500);
      expect_at(3199, M_F,   7'b0000000, "wd_not_yet");
      expect_at(3200, M_F,   7'b1000000, "wd_fault_set");
      expect_at(3201, M_ALL, 7'b1000000, "wd_gates_off");
      expect_at(3401, M_ALL, 7'b1000000, "wd_sticky_after_lock");
      expect_at(3500, M_ALL, 7'b1000000, "wd_sticky_later");
      lock_en = 1'b0;
      drive_carrier();
      goto(3300);
      lock_en = 1'b1;
      drive_carrier();

      // Only reset clears the fault.
      goto(3600);
      expect_at(3601, M_ALL, 7'b0000000, "fault_cleared_by_reset");
      expect_at(3650, M_ALL, 7'b0000000, "unarmed_after_fault_reset");
      reset_i = 1'b1;
      goto(3602);
      reset_i = 1'b0;
      goto(3660);

      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
